packet_builder: RTL and testbench

//  Transmit-side counterpart of packetFilter: serialises one outgoing routing packet (HB, CHE, INV, DATA, REWARD)

---
 rtl/pkt_defs.sv | 51 +++++
 rtl/pkt_byte_sel.sv | 71 +++++++
 rtl/packet_builder.sv | 135 +++++++++++++
 tb/tb_packet_builder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pkt_defs.sv
// Shared definitions for the transmit-side packet serialiser: type codes, frame
// lengths, fixed byte offsets, broadcast address and FSM state encoding.
package pkt_defs;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam logic [15:0] DEF_BROADCAST_ID = 16'hFFFF;

    localparam logic [2:0] PKT_HB     = 3'd1;
    localparam logic [2:0] PKT_CHE    = 3'd2;
    localparam logic [2:0] PKT_INV    = 3'd3;
    localparam logic [2:0] PKT_DATA   = 3'd4;
    localparam logic [2:0] PKT_REWARD = 3'd5;

    // Total frame length in bytes, checksum included.
    localparam logic [3:0] LEN_HB     = 4'd11;
    localparam logic [3:0] LEN_CHE    = 4'd10;
    localparam logic [3:0] LEN_INV    = 4'd8;
    localparam logic [3:0] LEN_DATA   = 4'd9;
    localparam logic [3:0] LEN_REWARD = 4'd8;

    localparam logic [3:0] IDX_TYPE    = 4'd0;
    localparam logic [3:0] IDX_SRC_HI  = 4'd1;
    localparam logic [3:0] IDX_SRC_LO  = 4'd2;
    localparam logic [3:0] IDX_DST_HI  = 4'd3;
    localparam logic [3:0] IDX_DST_LO  = 4'd4;
    localparam logic [3:0] IDX_PAYLOAD = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_CKSUM,
        ST_DONE
    } state_t;

    function automatic logic is_legal(input logic [2:0] t);
        return (t >= PKT_HB) && (t <= PKT_REWARD);
    endfunction

    function automatic logic [3:0] pkt_len(input logic [2:0] t);
        case (t)
            PKT_HB:     return LEN_HB;
            PKT_CHE:    return LEN_CHE;
            PKT_INV:    return LEN_INV;
            PKT_DATA:   return LEN_DATA;
            PKT_REWARD: return LEN_REWARD;
            default:    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/pkt_byte_sel.sv
// Combinational byte picker: maps latched packet fields and the current byte
// index onto the outgoing byte value (checksum byte is handled by the caller).
module pkt_byte_sel
    import pkt_defs::*;
#(
    parameter int WORD_WIDTH = WORD_W,
    parameter int BYTE_WIDTH = BYTE_W
) (
    input  logic [2:0]            i_type,
    input  logic [3:0]            i_idx,
    input  logic [WORD_WIDTH-1:0] i_src,
    input  logic [WORD_WIDTH-1:0] i_dst,
    input  logic [WORD_WIDTH-1:0] i_q,
    input  logic [WORD_WIDTH-1:0] i_energy,
    input  logic [WORD_WIDTH-1:0] i_data,
    input  logic [BYTE_WIDTH-1:0] i_hops,
    output logic [BYTE_WIDTH-1:0] o_byte
);

    logic [3:0] w_off;
    assign w_off = i_idx - IDX_PAYLOAD;

    always_comb begin
        // NOTE: default first so every path assigns o_byte and no latch is inferred.
        o_byte = '0;
        case (i_idx)
            IDX_TYPE:   o_byte = BYTE_WIDTH'(i_type);
            IDX_SRC_HI: o_byte = i_src[WORD_WIDTH-1 -: BYTE_WIDTH];
            IDX_SRC_LO: o_byte = i_src[BYTE_WIDTH-1:0];
            IDX_DST_HI: o_byte = i_dst[WORD_WIDTH-1 -: BYTE_WIDTH];
            IDX_DST_LO: o_byte = i_dst[BYTE_WIDTH-1:0];
            default: begin
                case (i_type)
                    PKT_HB: begin
                        case (w_off)
                            4'd0:    o_byte = i_q[WORD_WIDTH-1 -: BYTE_WIDTH];
                            4'd1:    o_byte = i_q[BYTE_WIDTH-1:0];
                            4'd2:    o_byte = i_hops;
                            4'd3:    o_byte = i_energy[WORD_WIDTH-1 -: BYTE_WIDTH];
                            4'd4:    o_byte = i_energy[BYTE_WIDTH-1:0];
                            default: o_byte = '0;
                        endcase
                    end
                    PKT_CHE: begin
                        case (w_off)
                            4'd0:    o_byte = i_energy[WORD_WIDTH-1 -: BYTE_WIDTH];
                            4'd1:    o_byte = i_energy[BYTE_WIDTH-1:0];
                            4'd2:    o_byte = i_q[WORD_WIDTH-1 -: BYTE_WIDTH];
                            4'd3:    o_byte = i_q[BYTE_WIDTH-1:0];
                            default: o_byte = '0;
                        endcase
                    end
                    PKT_INV:    o_byte = (w_off == 4'd0) ? i_energy[WORD_WIDTH-1 -: BYTE_WIDTH]
                                                         : i_energy[BYTE_WIDTH-1:0];
                    PKT_DATA: begin
                        case (w_off)
                            4'd0:    o_byte = i_data[WORD_WIDTH-1 -: BYTE_WIDTH];
                            4'd1:    o_byte = i_data[BYTE_WIDTH-1:0];
                            4'd2:    o_byte = i_hops;
                            default: o_byte = '0;
                        endcase
                    end
                    PKT_REWARD: o_byte = (w_off == 4'd0) ? i_q[WORD_WIDTH-1 -: BYTE_WIDTH]
                                                         : i_q[BYTE_WIDTH-1:0];
                    default:    o_byte = '0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/packet_builder.sv
// Serialises one routing packet (type, src, dst, payload, XOR checksum) onto a
// valid/ready byte stream; fields are captured when the packet is accepted.
module packet_builder
    import pkt_defs::*;
#(
    parameter int                    WORD_WIDTH   = WORD_W,
    parameter int                    BYTE_WIDTH   = BYTE_W,
    parameter logic [WORD_WIDTH-1:0] BROADCAST_ID = DEF_BROADCAST_ID
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [2:0]            pktType,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] destinationID,
    input  logic [WORD_WIDTH-1:0] qValue,
    input  logic [WORD_WIDTH-1:0] energy,
    input  logic [WORD_WIDTH-1:0] dataWord,
    input  logic [BYTE_WIDTH-1:0] hops,
    input  logic                  tx_ready,
    output logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t                r_state;
    logic [3:0]            r_idx;
    logic [3:0]            r_last_idx;
    logic [BYTE_WIDTH-1:0] r_cksum;
    logic [2:0]            r_type;
    logic [WORD_WIDTH-1:0] r_src, r_dst, r_q, r_energy, r_data;
    logic [BYTE_WIDTH-1:0] r_hops;
    logic                  r_valid, r_last, r_busy, r_done, r_err;
    logic [BYTE_WIDTH-1:0] w_byte;

    pkt_byte_sel #(
        .WORD_WIDTH (WORD_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_byte_sel (
        .i_type   (r_type),
        .i_idx    (r_idx),
        .i_src    (r_src),
        .i_dst    (r_dst),
        .i_q      (r_q),
        .i_energy (r_energy),
        .i_data   (r_data),
        .i_hops   (r_hops),
        .o_byte   (w_byte)
    );

    // Byte is a pure function of registered state, so it holds steady while stalled.
    assign tx_data  = (r_state == ST_SEND)  ? w_byte  :
                      (r_state == ST_CKSUM) ? r_cksum : '0;
    assign tx_valid = r_valid;
    assign tx_last  = r_last;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_cksum    <= '0;
            r_type     <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_q        <= '0;
            r_energy   <= '0;
            r_data     <= '0;
            r_hops     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && is_legal(pktType)) begin
                        r_type     <= pktType;
                        r_src      <= myNodeID;
                        r_dst      <= (pktType == PKT_HB || pktType == PKT_CHE) ? BROADCAST_ID
                                                                                : destinationID;
                        r_q        <= qValue;
                        r_energy   <= energy;
                        r_data     <= dataWord;
                        r_hops     <= hops;
                        r_idx      <= '0;
                        r_last_idx <= pkt_len(pktType) - 4'd2;
                        r_cksum    <= '0;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEND;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        r_cksum <= r_cksum ^ w_byte;
                        if (r_idx == r_last_idx) begin
                            r_last  <= 1'b1;
                            r_state <= ST_CKSUM;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (tx_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_builder.sv
// Directed bench for packet_builder: a reference byte model fills a scoreboard
// queue at start, and every accepted output byte is popped and compared.
module tb_packet_builder;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [2:0]  pktType;
    logic [15:0] myNodeID, destinationID, qValue, energy, dataWord;
    logic [7:0]  hops;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last, busy, done, err;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    packet_builder dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .pktType       (pktType),
        .myNodeID      (myNodeID),
        .destinationID (destinationID),
        .qValue        (qValue),
        .energy        (energy),
        .dataWord      (dataWord),
        .hops          (hops),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame builder; pushes the full expected byte sequence.
    task automatic push_expected(input logic [2:0] t, input logic [15:0] s, d, q, e, w,
                                 input logic [7:0] h);
        logic [7:0]  b[$];
        logic [7:0]  x;
        logic [15:0] dd;
        dd = (t == 3'd1 || t == 3'd2) ? 16'hFFFF : d;
        b.push_back({5'b0, t});
        b.push_back(s[15:8]);  b.push_back(s[7:0]);
        b.push_back(dd[15:8]); b.push_back(dd[7:0]);
        case (t)
            3'd1: begin b.push_back(q[15:8]); b.push_back(q[7:0]); b.push_back(h);
                        b.push_back(e[15:8]); b.push_back(e[7:0]); end
            3'd2: begin b.push_back(e[15:8]); b.push_back(e[7:0]);
                        b.push_back(q[15:8]); b.push_back(q[7:0]); end
            3'd3: begin b.push_back(e[15:8]); b.push_back(e[7:0]); end
            3'd4: begin b.push_back(w[15:8]); b.push_back(w[7:0]); b.push_back(h); end
            3'd5: begin b.push_back(q[15:8]); b.push_back(q[7:0]); end
            default: ;
        endcase
        x = 8'h00;
        foreach (b[i]) x ^= b[i];
        b.push_back(x);
        foreach (b[i]) sb.push_back(b[i]);
    endtask

    task automatic run_packet(input string name, input logic [2:0] t,
                              input logic [15:0] s, d, q, e, w, input logic [7:0] h,
                              input bit stall, input bit hold_mutate);
        int         exp_len, got, cyc;
        bit         finished, stalled_prev, rdy;
        logic [7:0] held, eb;
        push_expected(t, s, d, q, e, w, h);
        exp_len = sb.size();
        @(negedge clk);
        pktType = t; myNodeID = s; destinationID = d; qValue = q;
        energy = e; dataWord = w; hops = h; start = 1'b1;
        @(negedge clk);
        if (hold_mutate) begin
            pktType = 3'd5; myNodeID = ~s; destinationID = ~d; qValue = 16'hDEAD;
            energy = 16'hBEEF; dataWord = 16'h5A5A; hops = 8'hEE;
        end else begin
            start = 1'b0;
        end
        chk({name, " valid after start"}, tx_valid, 1);
        chk({name, " busy after start"}, busy, 1);
        got = 0; cyc = 0; finished = 0; stalled_prev = 0; held = 8'h00;
        while (!finished && cyc < 200) begin
            rdy = stall ? (cyc % 3 == 0) : 1'b1;
            if (stalled_prev) begin
                chk({name, " held data"}, tx_data, held);
                chk({name, " held valid"}, tx_valid, 1);
            end
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                eb = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
                chk($sformatf("%s byte%0d", name, got), tx_data, eb);
                chk($sformatf("%s last%0d", name, got), tx_last, (sb.size() == 0));
                got++;
                if (sb.size() == 0) finished = 1;
                stalled_prev = 0;
            end else begin
                stalled_prev = tx_valid;
                held = tx_data;
            end
            cyc++;
            @(negedge clk);
        end
        chk({name, " finished in budget"}, finished, 1);
        chk({name, " length"}, got, exp_len);
        chk({name, " done pulse"}, done, 1);
        chk({name, " busy in done"}, busy, 0);
        chk({name, " valid in done"}, tx_valid, 0);
        @(negedge clk);
        start = 1'b0;
        chk({name, " done cleared"}, done, 0);
        chk({name, " no restart from done"}, tx_valid, 0);
        chk({name, " idle not busy"}, busy, 0);
        sb.delete();
    endtask

    initial begin
        logic [7:0] eb;
        nrst = 1'b1; start = 1'b0; pktType = '0; myNodeID = '0; destinationID = '0;
        qValue = '0; energy = '0; dataWord = '0; hops = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset tx_last", tx_last, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        nrst = 1'b0;

        // REWARD: expected 05 00 0A 00 03 12 34 2A
        run_packet("reward", 3'd5, 16'h000A, 16'h0003, 16'h1234, 16'h0000, 16'h0000, 8'h00, 0, 0);
        // HB: dst forced to broadcast, 11 bytes
        run_packet("hb", 3'd1, 16'h0001, 16'h0009, 16'h5678, 16'hABCD, 16'h0000, 8'h07, 0, 0);
        // DATA with stalls
        run_packet("data_stall", 3'd4, 16'h0102, 16'h0304, 16'h0000, 16'h0000, 16'hC0DE, 8'h03, 1, 0);

        // Illegal type
        @(negedge clk);
        pktType = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal err pulse", err, 1);
        chk("illegal no valid", tx_valid, 0);
        chk("illegal not busy", busy, 0);
        @(negedge clk);
        chk("illegal err one cycle", err, 0);

        // CHE aborted by reset while byte 4 is presented
        push_expected(3'd2, 16'h0011, 16'h0022, 16'h3344, 16'h5566, 16'h0000, 8'h00);
        @(negedge clk);
        pktType = 3'd2; myNodeID = 16'h0011; destinationID = 16'h0022; qValue = 16'h3344;
        energy = 16'h5566; start = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            eb = sb.pop_front();
            chk($sformatf("che byte%0d", i), tx_data, eb);
            @(negedge clk);
        end
        nrst = 1'b1;
        @(negedge clk);
        chk("abort tx_valid", tx_valid, 0);
        chk("abort tx_data", tx_data, 0);
        chk("abort tx_last", tx_last, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        nrst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort no done later", done, 0);
        run_packet("inv_after_abort", 3'd3, 16'h0042, 16'h0077, 16'h0000, 16'h9ABC, 16'h0000, 8'h00, 0, 0);

        // Start held high and fields changed mid-packet
        run_packet("hb_hold", 3'd1, 16'h1357, 16'h2468, 16'h0F0F, 16'hF00D, 16'h0000, 8'h21, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
